// File: rtl/bus_mailbox_pkg.sv
// Register map, bit positions and read-handshake state type for bus_mailbox.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package bus_mailbox_pkg;

  // Word offsets on the core bus
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_IE     = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // STATUS fields
  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_TX_NONFULL  = 1;
  localparam int ST_TX_OVERFLOW = 2;
  localparam int ST_RX_UNDERFLOW = 3;
  localparam int ST_RX_CNT_LSB  = 8;
  localparam int ST_TX_CNT_LSB  = 16;

  // IE fields
  localparam int IE_RX_NONEMPTY = 0;
  localparam int IE_TX_EMPTY    = 1;

  // CTRL fields
  localparam int CTRL_FLUSH_RX = 0;
  localparam int CTRL_FLUSH_TX = 1;

  // Read handshake: IDLE accepts a read (wait state), RESP presents readdata
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/bus_mailbox_fifo_sync.sv
// Synchronous FIFO with first-word-fall-through head, used for the TX and RX paths.
// Latency: push visible at rdata/count one cycle later; rdata is combinational from storage.
// Backpressure: push ignored when full, pop ignored when empty; flush overrides both.
//
// Ports: push/wdata write side, pop consumes head, flush clears pointers and count
// (storage untouched), rdata = head, count/full/empty from registered state.
module fifo_sync #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the count held at the start of the cycle
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage has no reset; flush only rewinds the pointers
  always_ff @(posedge clock) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_mailbox.sv
// Core-bus mailbox bridging register accesses to a TX (out) and RX (in) valid/ready stream.
// Latency: reads take one wait state; writes complete with zero wait states.
// Backpressure: in_ready = RX not full; BUS_MAILBOX_BLOCKING_EN stalls DATA accesses on full/empty.
//
// Ports: clock/reset_n; address/writedata/readdata/read/write/waitrequest bus slave;
// irq level interrupt; out_* TX stream source; in_* RX stream sink.
// Build option: define BUS_MAILBOX_BLOCKING_EN to stall instead of flagging overflow/underflow.
module bus_mailbox
  import bus_mailbox_pkg::*;
#(
  parameter int WIDTHD = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic [WIDTHD-1:0] writedata,
  output logic [WIDTHD-1:0] readdata,
  input  logic              read,
  input  logic              write,
  output logic              waitrequest,
  output logic              irq,
  output logic [WIDTHD-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [WIDTHD-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  rd_state_e         state_q, state_d;
  logic [WIDTHD-1:0] readdata_q;
  logic [WIDTHD-1:0] rd_word;
  logic [31:0]       status_word;
  logic              tx_ovf_q, rx_udf_q;
  logic [1:0]        ie_q;

  logic              rd_capture, rd_wait, rd_block, wr_block, wr_fire;
  logic              tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [CW-1:0]     tx_count, rx_count;
  logic [WIDTHD-1:0] rx_rdata;

  // DATA accesses that cannot proceed: stalled in the blocking build, never otherwise
`ifdef BUS_MAILBOX_BLOCKING_EN
  assign rd_block = (address == REG_DATA) & rx_empty;
  assign wr_block = (address == REG_DATA) & tx_full;
`else
  assign rd_block = 1'b0;
  assign wr_block = 1'b0;
`endif

  // Read handshake; RESP is the completion cycle, so a held read pops only once
  always_comb begin
    state_d    = state_q;
    rd_capture = 1'b0;
    rd_wait    = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (read) begin
          rd_wait = 1'b1;
          if (!rd_block) begin
            rd_capture = 1'b1;
            state_d    = RD_RESP;
          end
        end
      end
      RD_RESP: state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  // Reads take priority over a simultaneous write strobe
  assign wr_fire     = write & ~read & ~wr_block;
  assign waitrequest = rd_wait | (write & ~read & wr_block);

  assign tx_push  = wr_fire & (address == REG_DATA);
  assign tx_pop   = out_valid & out_ready;
  assign tx_flush = wr_fire & (address == REG_CTRL) & writedata[CTRL_FLUSH_TX];
  assign rx_push  = in_valid & in_ready;
  assign rx_pop   = rd_capture & (address == REG_DATA);
  assign rx_flush = wr_fire & (address == REG_CTRL) & writedata[CTRL_FLUSH_RX];

  always_comb begin
    status_word                            = '0;
    status_word[ST_RX_NONEMPTY]            = ~rx_empty;
    status_word[ST_TX_NONFULL]             = ~tx_full;
    status_word[ST_TX_OVERFLOW]            = tx_ovf_q;
    status_word[ST_RX_UNDERFLOW]           = rx_udf_q;
    status_word[ST_RX_CNT_LSB +: 8]        = 8'(rx_count);
    status_word[ST_TX_CNT_LSB +: 8]        = 8'(tx_count);
  end

  always_comb begin
    rd_word = '0;
    case (address)
      REG_DATA:   rd_word = rx_empty ? '0 : rx_rdata;
      REG_STATUS: rd_word = WIDTHD'(status_word);
      REG_IE: begin
        rd_word[IE_RX_NONEMPTY] = ie_q[IE_RX_NONEMPTY];
        rd_word[IE_TX_EMPTY]    = ie_q[IE_TX_EMPTY];
      end
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RD_IDLE;
      readdata_q <= '0;
      tx_ovf_q   <= 1'b0;
      rx_udf_q   <= 1'b0;
      ie_q       <= '0;
    end else begin
      state_q <= state_d;
      if (rd_capture) readdata_q <= rd_word;
      if (wr_fire && address == REG_IE) begin
        ie_q <= writedata[1:0];
      end
      if (wr_fire && address == REG_STATUS && writedata[ST_TX_OVERFLOW]) tx_ovf_q <= 1'b0;
      if (wr_fire && address == REG_STATUS && writedata[ST_RX_UNDERFLOW]) rx_udf_q <= 1'b0;
`ifndef BUS_MAILBOX_BLOCKING_EN
      if (tx_push && tx_full) tx_ovf_q <= 1'b1;
      if (rx_pop && rx_empty) rx_udf_q <= 1'b1;
`endif
    end
  end

  assign readdata  = readdata_q;
  assign out_valid = ~tx_empty;
  assign in_ready  = ~rx_full;
  assign irq       = (ie_q[IE_RX_NONEMPTY] & ~rx_empty) | (ie_q[IE_TX_EMPTY] & tx_empty);

  fifo_sync #(.WIDTH(WIDTHD), .DEPTH(DEPTH)) u_tx_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (tx_push),
    .wdata   (writedata),
    .pop     (tx_pop),
    .flush   (tx_flush),
    .rdata   (out_data),
    .count   (tx_count),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  fifo_sync #(.WIDTH(WIDTHD), .DEPTH(DEPTH)) u_rx_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (rx_push),
    .wdata   (in_data),
    .pop     (rx_pop),
    .flush   (rx_flush),
    .rdata   (rx_rdata),
    .count   (rx_count),
    .full    (rx_full),
    .empty   (rx_empty)
  );

endmodule

// File: tb/tb_bus_mailbox.sv
`timescale 1ns/1ps
module tb_bus_mailbox;

  localparam int WIDTHD = 32;
  localparam int DEPTH  = 16;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        address = '0;
  logic [WIDTHD-1:0] writedata = '0;
  logic [WIDTHD-1:0] readdata;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic              waitrequest;
  logic              irq;
  logic [WIDTHD-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTHD-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  bus_mailbox #(.WIDTHD(WIDTHD), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .irq         (irq),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready)
  );

  // Bus read: w = number of cycles waitrequest was seen high (bounded)
  task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output int w);
    @(negedge clock);
    address = a;
    read = 1'b1;
    w = 0;
    #1;
    while (waitrequest && w < 64) begin
      @(negedge clock);
      #1;
      w++;
    end
    d = readdata;
    read = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int w);
    @(negedge clock);
    address = a;
    writedata = d;
    write = 1'b1;
    w = 0;
    #1;
    while (waitrequest && w < 64) begin
      @(negedge clock);
      #1;
      w++;
    end
    @(posedge clock);
    #1;
    write = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int w;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (waitrequest !== 1'b0) begin failures++; $display("FAIL reset_waitrequest got=%b exp=0", waitrequest); end
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    reset_n = 1'b1;
    bus_read(2'd1, d, w);
    checks++; if (w !== 1) begin failures++; $display("FAIL reset_status_waits got=%0d exp=1", w); end
    checks++; if (d !== 32'h0000_0002) begin failures++; $display("FAIL reset_status got=%h exp=00000002", d); end
  endtask

  task automatic test_tx_stream();
    logic [31:0] d;
    logic [31:0] exp_words [3];
    int w;
    exp_words[0] = 32'h11; exp_words[1] = 32'h22; exp_words[2] = 32'h33;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus_write(2'd0, exp_words[i], w);
    bus_read(2'd1, d, w);
    checks++; if (d !== 32'h0003_0002) begin failures++; $display("FAIL tx_status got=%h exp=00030002", d); end
    @(negedge clock);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_words[i]) begin
        failures++; $display("FAIL tx_out_%0d got=%b/%h exp=1/%h", i, out_valid, out_data, exp_words[i]);
      end
      @(negedge clock);
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL tx_drained out_valid got=%b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_rx_fill();
    logic [31:0] d;
    int w;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rx_fill_ready_%0d got=%b exp=1", i, in_ready); end
      in_data = 32'(i);
      in_valid = 1'b1;
    end
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rx_full_in_ready got=%b exp=0", in_ready); end
    bus_read(2'd1, d, w);
    checks++; if (d !== 32'h0000_1003) begin failures++; $display("FAIL rx_full_status got=%h exp=00001003", d); end
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(2'd0, d, w);
      checks++;
      if (d !== 32'(i) || w !== 1) begin
        failures++; $display("FAIL rx_read_%0d got=%h waits=%0d exp=%h waits=1", i, d, w, i);
      end
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rx_drained_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int w;
    @(negedge clock); in_data = 32'hA; in_valid = 1'b1;
    @(negedge clock); in_data = 32'hB;
    @(negedge clock); in_valid = 1'b0;
    address = 2'd0; read = 1'b1;   // held high across two transfers
    #1;
    checks++; if (waitrequest !== 1'b1) begin failures++; $display("FAIL b2b_wait0 got=%b exp=1", waitrequest); end
    @(negedge clock); #1;
    checks++; if (waitrequest !== 1'b0 || readdata !== 32'hA) begin failures++; $display("FAIL b2b_first got=%b/%h exp=0/0000000a", waitrequest, readdata); end
    @(negedge clock); #1;
    checks++; if (waitrequest !== 1'b1) begin failures++; $display("FAIL b2b_wait1 got=%b exp=1", waitrequest); end
    @(negedge clock); #1;
    checks++; if (waitrequest !== 1'b0 || readdata !== 32'hB) begin failures++; $display("FAIL b2b_second got=%b/%h exp=0/0000000b", waitrequest, readdata); end
    read = 1'b0;
    bus_read(2'd1, d, w);
    checks++; if (d !== 32'h0000_0002) begin failures++; $display("FAIL b2b_status got=%h exp=00000002", d); end
  endtask

`ifndef BUS_MAILBOX_BLOCKING_EN
  task automatic test_overflow();
    logic [31:0] d;
    int w;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus_write(2'd0, 32'h100 + 32'(i), w);
      checks++; if (w !== 0) begin failures++; $display("FAIL ovf_write_waits_%0d got=%0d exp=0", i, w); end
    end
    bus_read(2'd1, d, w);
    checks++; if (d !== 32'h0010_0004) begin failures++; $display("FAIL ovf_status got=%h exp=00100004", d); end
    checks++; if (out_data !== 32'h100) begin failures++; $display("FAIL ovf_head got=%h exp=00000100", out_data); end
    bus_write(2'd1, 32'h4, w);
    bus_read(2'd1, d, w);
    checks++; if (d !== 32'h0010_0000) begin failures++; $display("FAIL ovf_clear got=%h exp=00100000", d); end
    bus_read(2'd0, d, w);
    checks++; if (d !== 32'h0 || w !== 1) begin failures++; $display("FAIL udf_read got=%h waits=%0d exp=0 waits=1", d, w); end
    bus_read(2'd1, d, w);
    checks++; if (d !== 32'h0010_0008) begin failures++; $display("FAIL udf_status got=%h exp=00100008", d); end
    bus_write(2'd1, 32'h8, w);
    bus_write(2'd3, 32'h2, w);
    bus_read(2'd1, d, w);
    checks++; if (d !== 32'h0000_0002) begin failures++; $display("FAIL flush_tx_status got=%h exp=00000002", d); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_tx_out_valid got=%b exp=0", out_valid); end
  endtask
`else
  task automatic test_blocking();
    logic [31:0] d;
    int w;
    // Read on empty RX stalls until the stream delivers a word
    @(negedge clock);
    address = 2'd0; read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (waitrequest !== 1'b1) begin failures++; $display("FAIL blk_rd_stall_%0d got=%b exp=1", k, waitrequest); end
      @(negedge clock);
    end
    in_data = 32'hCAFE; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    w = 0;
    #1;
    while (waitrequest && w < 64) begin @(negedge clock); #1; w++; end
    checks++; if (w !== 1 || readdata !== 32'hCAFE) begin failures++; $display("FAIL blk_rd_data got=%h waits=%0d exp=0000cafe waits=1", readdata, w); end
    read = 1'b0;
    // Write on full TX stalls until a word drains, then pushes
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) bus_write(2'd0, 32'h100 + 32'(i), w);
    @(negedge clock);
    address = 2'd0; writedata = 32'hBEEF; write = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (waitrequest !== 1'b1) begin failures++; $display("FAIL blk_wr_stall_%0d got=%b exp=1", k, waitrequest); end
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    #1;
    checks++; if (waitrequest !== 1'b0) begin failures++; $display("FAIL blk_wr_release got=%b exp=0", waitrequest); end
    @(posedge clock); #1;
    write = 1'b0;
    bus_read(2'd1, d, w);
    checks++; if (d !== 32'h0010_0000) begin failures++; $display("FAIL blk_status got=%h exp=00100000", d); end
    checks++; if (out_data !== 32'h101) begin failures++; $display("FAIL blk_head got=%h exp=00000101", out_data); end
    bus_write(2'd3, 32'h2, w);
  endtask
`endif

  task automatic test_irq();
    logic [31:0] d;
    int w;
    bus_write(2'd2, 32'h1, w);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_idle got=%b exp=0", irq); end
    @(negedge clock); in_data = 32'h55; in_valid = 1'b1;
    @(negedge clock); in_valid = 1'b0;
    #1;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rx got=%b exp=1", irq); end
    // Flush RX with a simultaneous stream push: flush wins
    @(negedge clock);
    address = 2'd3; writedata = 32'h1; write = 1'b1;
    in_data = 32'h66; in_valid = 1'b1;
    @(negedge clock);
    write = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_after_flush got=%b exp=0", irq); end
    bus_read(2'd1, d, w);
    checks++; if (d !== 32'h0000_0002) begin failures++; $display("FAIL flush_rx_status got=%h exp=00000002", d); end
    bus_read(2'd2, d, w);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL ie_readback got=%h exp=00000001", d); end
    bus_write(2'd2, 32'h2, w);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_tx_empty got=%b exp=1", irq); end
    out_ready = 1'b0;
    bus_write(2'd0, 32'h77, w);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_tx_busy got=%b exp=0", irq); end
    @(negedge clock); out_ready = 1'b1;
    @(negedge clock); out_ready = 1'b0;
    #1;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_tx_drained got=%b exp=1", irq); end
    bus_read(2'd3, d, w);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL ctrl_read got=%h exp=0", d); end
    bus_write(2'd2, 32'h0, w);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int w;
    @(negedge clock); in_data = 32'h99; in_valid = 1'b1;
    @(negedge clock); in_valid = 1'b0;
    address = 2'd0; read = 1'b1;
    #1;
    checks++; if (waitrequest !== 1'b1) begin failures++; $display("FAIL mid_wait got=%b exp=1", waitrequest); end
    reset_n = 1'b0;
    read = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks++; if (waitrequest !== 1'b0 || readdata !== 32'h0) begin failures++; $display("FAIL mid_after_reset got=%b/%h exp=0/0", waitrequest, readdata); end
    bus_read(2'd1, d, w);
    checks++; if (d !== 32'h0000_0002 || w !== 1) begin failures++; $display("FAIL mid_status got=%h waits=%0d exp=00000002 waits=1", d, w); end
  endtask

  initial begin
    test_reset();
    test_tx_stream();
    test_rx_fill();
    test_back_to_back();
`ifndef BUS_MAILBOX_BLOCKING_EN
    test_overflow();
`else
    test_blocking();
`endif
    test_irq();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
